// File: rtl/approx_mul_share_ctrl.sv
// approx_mul_share_ctrl
//   Shares one external combinational 8x8 unsigned approximate multiplier among
//   NUM_REQ requesters. Requests are arbitrated round-robin, pushed through a
//   fixed LAT-cycle result pipeline and returned tagged with the requester ID.
//   An IDLE/RUN/DRAIN state machine lets the shared multiplier be stopped
//   cleanly: dropping en stops new grants and lets in-flight work finish.
//
// Optional feature macro: APPROX_MUL_ERR_STAT_EN
//   When defined, an exact product travels alongside each result and
//   err_cnt / err_max report mismatch count and maximum absolute error.
//   When undefined, err_cnt and err_max are tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   en                1 = grant new requests, 0 = drain and stop
//   req_valid/ready   per-requester handshake, req_ready is one-hot or zero
//   req_x, req_y      packed operands, requester i at [8i+7:8i]
//   mul_x, mul_y      registered operands to the multiplier (stage 1)
//   mul_z             combinational product back from the multiplier
//   rsp_valid/ready   response handshake
//   rsp_id, rsp_z     requester ID and product of the response
//   idle              1 while the state machine is IDLE
//   done_cnt          completed responses, wraps
//   err_cnt, err_max  error statistics (optional feature)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. A source holding valid must keep its data stable until the
// transfer. req_ready depends combinationally on req_valid; rsp_valid never
// depends on rsp_ready.
module approx_mul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LAT     = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [8*NUM_REQ-1:0] req_y,
  output logic [7:0]           mul_x,
  output logic [7:0]           mul_y,
  input  logic [15:0]          mul_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_z,
  output logic                 idle,
  output logic [CNT_W-1:0]     done_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [15:0]          err_max
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] sel;
  logic            sel_found;
  logic            stall;
  logic            accept;
  logic            pipe_empty;

  // Stage 1: operands held in front of the multiplier.
  logic            s1_v_q;
  logic [7:0]      s1_x_q, s1_y_q;
  logic [ID_W-1:0] s1_id_q;

  // Stages 2..LAT: product and ID, stage LAT drives the response port.
  logic [LAT:2]    pv_q;
  logic [ID_W-1:0] pid_q [2:LAT];
  logic [15:0]     pz_q  [2:LAT];

  logic [CNT_W-1:0] done_q;

  // The whole pipeline freezes while a response is offered but not taken.
  assign stall      = pv_q[LAT] & ~rsp_ready;
  assign pipe_empty = ~s1_v_q & ~(|pv_q);

  // Round-robin pick: first valid requester at or above the pointer, wrapping.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!sel_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel       = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == ST_RUN) && !stall && sel_found) begin
      req_ready[sel] = 1'b1;
    end
  end

  assign accept = |req_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)              state_d = ST_RUN;
        else if (pipe_empty) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      done_q  <= '0;
      s1_v_q  <= 1'b0;
      s1_x_q  <= '0;
      s1_y_q  <= '0;
      s1_id_q <= '0;
      pv_q    <= '0;
      for (int k = 2; k <= LAT; k++) begin
        pid_q[k] <= '0;
        pz_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (rsp_valid && rsp_ready) begin
        done_q <= done_q + CNT_W'(1);
      end
      if (!stall) begin
        s1_v_q <= accept;
        if (accept) begin
          s1_x_q  <= req_x[8*int'(sel) +: 8];
          s1_y_q  <= req_y[8*int'(sel) +: 8];
          s1_id_q <= sel;
        end
        pv_q[2]  <= s1_v_q;
        pid_q[2] <= s1_id_q;
        pz_q[2]  <= mul_z;
        for (int k = 3; k <= LAT; k++) begin
          pv_q[k]  <= pv_q[k-1];
          pid_q[k] <= pid_q[k-1];
          pz_q[k]  <= pz_q[k-1];
        end
      end
    end
  end

  assign mul_x     = s1_x_q;
  assign mul_y     = s1_y_q;
  assign rsp_valid = pv_q[LAT];
  assign rsp_id    = pid_q[LAT];
  assign rsp_z     = pz_q[LAT];
  assign idle      = (state_q == ST_IDLE);
  assign done_cnt  = done_q;

`ifdef APPROX_MUL_ERR_STAT_EN
  logic [15:0]      pe_q [2:LAT];
  logic [CNT_W-1:0] err_cnt_q;
  logic [15:0]      err_max_q;
  logic [15:0]      abs_diff;

  assign abs_diff = (rsp_z >= pe_q[LAT]) ? (rsp_z - pe_q[LAT]) : (pe_q[LAT] - rsp_z);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_max_q <= '0;
      for (int k = 2; k <= LAT; k++) begin
        pe_q[k] <= '0;
      end
    end else begin
      if (!stall) begin
        pe_q[2] <= 16'(s1_x_q) * 16'(s1_y_q);
        for (int k = 3; k <= LAT; k++) begin
          pe_q[k] <= pe_q[k-1];
        end
      end
      if (rsp_valid && rsp_ready) begin
        if ((rsp_z != pe_q[LAT]) && !(&err_cnt_q)) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
        if (abs_diff > err_max_q) begin
          err_max_q <= abs_diff;
        end
      end
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`else
  assign err_cnt = '0;
  assign err_max = '0;
`endif

endmodule

// File: tb/tb_approx_mul_share_ctrl.sv
// Testbench for approx_mul_share_ctrl.
// A behavioural model (queue of in-flight results with ages) predicts every
// response, the round-robin grant and the enable/drain state each cycle; a
// monitor on the falling edge compares the DUT against it.
module tb_approx_mul_share_ctrl;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 2;
  localparam int CNT_W   = 16;
  localparam int EW      = 48 + ID_W;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  localparam int M_ONESHOT = 0;
  localparam int M_HOLD    = 1;
  localparam int M_RAND    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  initial forever #5 clk = ~clk;

  logic                 en;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_x, req_y;
  logic [7:0]           mul_x, mul_y;
  logic [15:0]          mul_z;
  logic                 rsp_valid, rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_z;
  logic                 idle;
  logic [CNT_W-1:0]     done_cnt, err_cnt;
  logic [15:0]          err_max;

  logic [7:0] rx [NUM_REQ];
  logic [7:0] ry [NUM_REQ];

  approx_mul_share_ctrl #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z),
    .idle(idle), .done_cnt(done_cnt),
    .err_cnt(err_cnt), .err_max(err_max)
  );

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_x[8*i +: 8] = rx[i];
      req_y[8*i +: 8] = ry[i];
    end
  end

  // Bench multiplier: exact, optionally corrupted in bit 0 when x = 255.
  always_comb begin
    mul_z = {8'd0, mul_x} * {8'd0, mul_y};
`ifdef APPROX_MUL_ERR_STAT_EN
    if (mul_x == 8'hFF) mul_z[0] = ~mul_z[0];
`endif
  end

  function automatic logic [15:0] approx_ref(input int x, input int y);
    int p;
    p = x * y;
`ifdef APPROX_MUL_ERR_STAT_EN
    if (x == 255) p = p ^ 1;
`endif
    return 16'(p);
  endfunction

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- requester driver ----------------
  int          mode = M_ONESHOT;
  int          cmd_seq [NUM_REQ];
  logic [7:0]  cmd_x [NUM_REQ];
  logic [7:0]  cmd_y [NUM_REQ];
  int          tk_seq [NUM_REQ];
  logic [NUM_REQ-1:0] acc = '0;   // model's accepted vector for the last cycle

  initial begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rx[i] = '0; ry[i] = '0; tk_seq[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          if (mode == M_HOLD || (mode == M_RAND && $urandom_range(0, 1) == 1)) begin
            rx[i] = rnd8(); ry[i] = rnd8();
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if (!req_valid[i]) begin
          if (cmd_seq[i] != tk_seq[i]) begin
            req_valid[i] = 1'b1; rx[i] = cmd_x[i]; ry[i] = cmd_y[i]; tk_seq[i] = cmd_seq[i];
          end else if (mode == M_RAND && $urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1; rx[i] = rnd8(); ry[i] = rnd8();
          end
        end
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [EW-1:0] exp_q [$];   // {x, y, id, approx z, exact}, oldest first
  int            age_q [$];   // pipeline position of each entry (0 = stage 1)
  int            m_state = S_IDLE;
  int            m_ptr = 0;
  logic [CNT_W-1:0] m_done = '0;
  logic [CNT_W-1:0] m_errcnt = '0;
  logic [15:0]      m_errmax = '0;
  logic          stall_prev = 1'b0;
  logic [7:0]    prev_mx, prev_my;
  logic          exp_rv, stall_m, found, empty_m;
  int            pick;
  logic [NUM_REQ-1:0] gnt;
  logic [EW-1:0] head, ent;
  logic [15:0]   hz, he, hd;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); age_q.delete();
      m_state = S_IDLE; m_ptr = 0; m_done = '0; m_errcnt = '0; m_errmax = '0;
      acc = '0; stall_prev = 1'b0;
    end else begin
      exp_rv = (exp_q.size() > 0) && (age_q[0] == LAT - 1);
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        head = exp_q[0];
        check("rsp_id", 64'(rsp_id), 64'(head[32 +: ID_W]));
        check("rsp_z", 64'(rsp_z), 64'(head[16 +: 16]));
      end
      stall_m = exp_rv && !rsp_ready;

      found = 1'b0; pick = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req_valid[(m_ptr + k) % NUM_REQ]) begin
          found = 1'b1; pick = (m_ptr + k) % NUM_REQ;
        end
      end
      gnt = '0;
      if (m_state == S_RUN && !stall_m && found) gnt[pick] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(gnt));
      check("idle", 64'(idle), 64'(m_state == S_IDLE));
      check("done_cnt", 64'(done_cnt), 64'(m_done));
      check("err_cnt", 64'(err_cnt), 64'(m_errcnt));
      check("err_max", 64'(err_max), 64'(m_errmax));
      if (stall_prev) begin
        check("mul_x_hold", 64'(mul_x), 64'(prev_mx));
        check("mul_y_hold", 64'(mul_y), 64'(prev_my));
      end
      if (age_q.size() > 0 && age_q[age_q.size()-1] == 0) begin
        ent = exp_q[exp_q.size()-1];
        check("mul_x", 64'(mul_x), 64'(ent[EW-1 -: 8]));
        check("mul_y", 64'(mul_y), 64'(ent[EW-9 -: 8]));
      end

      // advance the model across the coming rising edge
      empty_m = (exp_q.size() == 0);
      if (exp_rv && rsp_ready) begin
        head = exp_q.pop_front();
        void'(age_q.pop_front());
        m_done = m_done + 1'b1;
`ifdef APPROX_MUL_ERR_STAT_EN
        hz = head[16 +: 16]; he = head[0 +: 16];
        if (hz != he && m_errcnt != '1) m_errcnt = m_errcnt + 1'b1;
        hd = (hz > he) ? hz - he : he - hz;
        if (hd > m_errmax) m_errmax = hd;
`endif
      end
      if (!stall_m) begin
        foreach (age_q[j]) age_q[j] = age_q[j] + 1;
      end
      if (gnt != '0) begin
        exp_q.push_back({rx[pick], ry[pick], ID_W'(pick), approx_ref(int'(rx[pick]), int'(ry[pick])),
                         16'(int'(rx[pick]) * int'(ry[pick]))});
        age_q.push_back(0);
        m_ptr = (pick + 1) % NUM_REQ;
      end
      case (m_state)
        S_IDLE:  if (en) m_state = S_RUN;
        S_RUN:   if (!en) m_state = S_DRAIN;
        default: begin
          if (en) m_state = S_RUN;
          else if (empty_m) m_state = S_IDLE;
        end
      endcase
      acc = gnt;
      stall_prev = stall_m;
      prev_mx = mul_x; prev_my = mul_y;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic raise(input int i, input logic [7:0] x, input logic [7:0] y);
    cmd_x[i] = x; cmd_y[i] = y; cmd_seq[i] = cmd_seq[i] + 1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int bound);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (idle) seen = 1'b1;
    end
    check(name, 64'(seen), 64'(1));
    cyc(1);
  endtask

  initial begin
    int n, m;
    int g [8];
    int gc;
    logic hs;
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_seq[i] = 0; cmd_x[i] = '0; cmd_y[i] = '0;
    end
    rst_n = 1'b0; en = 1'b0; rsp_ready = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_mul_x", 64'(mul_x), 64'(0));
    check("rst_mul_y", 64'(mul_y), 64'(0));
    check("rst_rsp_z", 64'(rsp_z), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_done_cnt", 64'(done_cnt), 64'(0));
    cyc(1);

    // single request, latency and product
    en = 1'b1;
    cyc(2);
    raise(0, 8'd13, 8'd11);
    hs = 1'b0;
    for (n = 0; n < 20 && !hs; n++) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) hs = 1'b1;
    end
    check("first_accept_seen", 64'(hs), 64'(1));
    hs = 1'b0; m = 0;
    while (m < 20 && !hs) begin
      @(negedge clk);
      m++;
      if (rsp_valid) hs = 1'b1;
    end
    check("first_latency", 64'(m), 64'(LAT));
    check("first_rsp_id", 64'(rsp_id), 64'(0));
    check("first_rsp_z", 64'(rsp_z), 64'(143));
    @(negedge clk);
    check("first_done_cnt", 64'(done_cnt), 64'(1));
    cyc(2);

    // all requesters hold valid: strict rotation
    mode = M_HOLD;
    for (int i = 0; i < NUM_REQ; i++) raise(i, rnd8(), rnd8());
    gc = 0;
    for (int k = 0; k < 40 && gc < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && gc < 8) begin
          g[gc] = i; gc++;
        end
      end
    end
    check("rr_grant_count", 64'(gc), 64'(8));
    for (int k = 1; k < 8; k++) check("rr_order", 64'(g[k]), 64'((g[0] + k) % NUM_REQ));
    cyc(1);
    mode = M_ONESHOT;
    cyc(10);

    // response stall with requests in flight
    raise(0, rnd8(), rnd8()); raise(1, rnd8(), rnd8()); raise(2, rnd8(), rnd8());
    cyc(2);
    rsp_ready = 1'b0;
    cyc(5);
    rsp_ready = 1'b1;
    cyc(10);

    // drain with en low, then resume
    raise(2, rnd8(), rnd8()); raise(3, rnd8(), rnd8());
    cyc(2);
    en = 1'b0;
    wait_idle("drain_to_idle", 30);
    en = 1'b1;
    raise(1, 8'd7, 8'd9);
    cyc(10);

    // reset with requests in flight
    mode = M_HOLD;
    for (int i = 0; i < NUM_REQ; i++) raise(i, rnd8(), rnd8());
    cyc(4);
    pulse_reset();
    @(negedge clk);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_done_cnt", 64'(done_cnt), 64'(0));
    check("midrst_idle", 64'(idle), 64'(1));
    cyc(5);
    mode = M_ONESHOT;
    cyc(12);

`ifdef APPROX_MUL_ERR_STAT_EN
    pulse_reset();
    raise(0, 8'hFF, 8'hFF);
    raise(1, 8'd3, 8'd4);
    cyc(12);
    check("errstat_err_cnt", 64'(err_cnt), 64'(1));
    check("errstat_err_max", 64'(err_max), 64'(1));
`endif

    // randomized traffic with backpressure and enable toggling
    mode = M_RAND;
    for (int c = 0; c < 600; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      cyc(1);
    end
    mode = M_ONESHOT;
    rsp_ready = 1'b1;
    en = 1'b0;
    wait_idle("final_idle", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
